// File: rtl/counter_sequencer_if.sv
// Command/status bundle between counter_sequencer and its 74163-style counter.
// The master modport is the sequencer side; slave is the counter/host side.
interface counter_sequencer_if #(
   parameter int WRAP_W = 8
);
   logic              START;
   logic              STOP;
   logic [3:0]        PRELOAD;
   logic [3:0]        Q;
   logic              RCO;
   logic              ENP;
   logic              ENT;
   logic              LDb;
   logic              CLRb;
   logic [3:0]        D;
   logic              BUSY;
   logic              DONE;
   logic              ERR;
   logic [WRAP_W-1:0] WRAPS;

   modport master (
      input  START, STOP, PRELOAD, Q, RCO,
      output ENP, ENT, LDb, CLRb, D, BUSY, DONE, ERR, WRAPS
   );

   modport slave (
      output START, STOP, PRELOAD, Q, RCO,
      input  ENP, ENT, LDb, CLRb, D, BUSY, DONE, ERR, WRAPS
   );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencer for a 74163-style counter: clear, preload, paced stepping, wrap counting, DONE pulse.
// Optional macro SHADOW_CHECK_EN adds a shadow counter that flags Q/RCO mismatches (sticky ERR).
module counter_sequencer #(
   parameter int STEP_DIV    = 25_000_000,
   parameter int WRAP_TARGET = 4,
   parameter int WRAP_W      = 8
) (
   input logic                 CLK50M,
   input logic                 RST,
   counter_sequencer_if.master bus
);

   localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0]     PRESC_TERM  = PW'(STEP_DIV - 1);
   localparam logic [WRAP_W-1:0] WRAPS_LAST  = WRAP_W'(WRAP_TARGET - 1);
   localparam logic [WRAP_W-1:0] WRAPS_FINAL = WRAP_W'(WRAP_TARGET);

`ifdef SHADOW_CHECK_EN
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE, S_ERROR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE
   } state_t;
`endif

   state_t            state_reg;
   logic [PW-1:0]     presc_reg;
   logic [PW-1:0]     presc_next;
   logic [3:0]        preload_reg;
   logic              enp_reg;
   logic              ent_reg;
   logic              ldb_reg;
   logic              clrb_reg;
   logic [3:0]        d_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [WRAP_W-1:0] wraps_reg;
   logic              mismatch;

   always_comb begin
      presc_next = (presc_reg == PRESC_TERM) ? '0 : presc_reg + 1'b1;
   end

`ifdef SHADOW_CHECK_EN
   logic [3:0] shadow_reg;
   logic       err_reg;

   // Mirrors what the counter must do given the controls this block actually drove.
   always_ff @(posedge CLK50M) begin
      if (RST) begin
         shadow_reg <= 4'd0;
      end else if (!clrb_reg) begin
         shadow_reg <= 4'd0;
      end else if (!ldb_reg) begin
         shadow_reg <= d_reg;
      end else if (enp_reg && ent_reg) begin
         shadow_reg <= shadow_reg + 4'd1;
      end
   end

   always_comb begin
      mismatch = (bus.Q != shadow_reg) || (bus.RCO != (ent_reg && (shadow_reg == 4'hF)));
   end

   assign bus.ERR = err_reg;
`else
   logic unused_inputs;
   assign unused_inputs = ^{bus.Q};
   assign mismatch      = 1'b0;
   assign bus.ERR       = 1'b0;
`endif

   always_ff @(posedge CLK50M) begin
      if (RST) begin
         state_reg   <= S_IDLE;
         presc_reg   <= '0;
         preload_reg <= 4'd0;
         enp_reg     <= 1'b0;
         ent_reg     <= 1'b0;
         ldb_reg     <= 1'b1;
         clrb_reg    <= 1'b1;
         d_reg       <= 4'd0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         wraps_reg   <= '0;
`ifdef SHADOW_CHECK_EN
         err_reg     <= 1'b0;
`endif
      end else begin
         // Single-cycle strobes and load data fall back to idle unless a state re-asserts them.
         enp_reg  <= 1'b0;
         ent_reg  <= 1'b0;
         ldb_reg  <= 1'b1;
         clrb_reg <= 1'b1;
         d_reg    <= 4'd0;
         done_reg <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               if (bus.START && !bus.STOP) begin
                  state_reg   <= S_CLEAR;
                  preload_reg <= bus.PRELOAD;
                  wraps_reg   <= '0;
                  clrb_reg    <= 1'b0;
                  busy_reg    <= 1'b1;
               end
            end

            S_CLEAR: begin
               if (bus.STOP) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg <= S_LOAD;
                  ldb_reg   <= 1'b0;
                  d_reg     <= preload_reg;
               end
            end

            S_LOAD: begin
               presc_reg <= '0;
               if (bus.STOP) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg <= S_RUN;
               end
            end

            S_RUN: begin
               if (mismatch) begin
`ifdef SHADOW_CHECK_EN
                  state_reg <= S_ERROR;
                  err_reg   <= 1'b1;
`endif
                  busy_reg  <= 1'b0;
               end else if (bus.STOP) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  presc_reg <= presc_next;
                  enp_reg   <= (presc_next == PRESC_TERM);
                  ent_reg   <= (presc_next == PRESC_TERM);
                  // enp_reg high means this cycle is a step; RCO then marks a wrap.
                  if (enp_reg && bus.RCO) begin
                     if (wraps_reg != WRAPS_FINAL) begin
                        wraps_reg <= wraps_reg + 1'b1;
                     end
                     if (wraps_reg == WRAPS_LAST) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        enp_reg   <= 1'b0;
                        ent_reg   <= 1'b0;
                     end
                  end
               end
            end

            S_DONE: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end

            default: begin
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ENP   = enp_reg;
   assign bus.ENT   = ent_reg;
   assign bus.LDb   = ldb_reg;
   assign bus.CLRb  = clrb_reg;
   assign bus.D     = d_reg;
   assign bus.BUSY  = busy_reg;
   assign bus.DONE  = done_reg;
   assign bus.WRAPS = wraps_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural 74163 model.
// Instance 1 uses WRAP_TARGET=2, instance 2 uses WRAP_TARGET=1; both STEP_DIV=4.
module tb_counter_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic stuck;
   logic [3:0] cnt1;
   logic [3:0] cnt2;

   counter_sequencer_if #(.WRAP_W(8)) bus1 ();
   counter_sequencer_if #(.WRAP_W(8)) bus2 ();

   counter_sequencer #(.STEP_DIV(4), .WRAP_TARGET(2), .WRAP_W(8)) dut1 (
      .CLK50M (clk),
      .RST    (rst),
      .bus    (bus1.master)
   );

   counter_sequencer #(.STEP_DIV(4), .WRAP_TARGET(1), .WRAP_W(8)) dut2 (
      .CLK50M (clk),
      .RST    (rst),
      .bus    (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 74163 behavioural models: sync clear, sync load, count on ENP&ENT.
   always @(posedge clk) begin
      if (!bus1.CLRb)                cnt1 <= 4'd0;
      else if (!bus1.LDb)            cnt1 <= bus1.D;
      else if (bus1.ENP && bus1.ENT) cnt1 <= cnt1 + 4'd1;
   end
   always @(posedge clk) begin
      if (!bus2.CLRb)                cnt2 <= 4'd0;
      else if (!bus2.LDb)            cnt2 <= bus2.D;
      else if (bus2.ENP && bus2.ENT) cnt2 <= cnt2 + 4'd1;
   end

   assign bus1.Q   = stuck ? 4'd3 : cnt1;
   assign bus1.RCO = bus1.ENT && (bus1.Q == 4'hF);
   assign bus2.Q   = cnt2;
   assign bus2.RCO = bus2.ENT && (cnt2 == 4'hF);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle1(input string tag);
      chk({tag, "_enp"},  {31'd0, bus1.ENP},  32'd0);
      chk({tag, "_ent"},  {31'd0, bus1.ENT},  32'd0);
      chk({tag, "_ldb"},  {31'd0, bus1.LDb},  32'd1);
      chk({tag, "_clrb"}, {31'd0, bus1.CLRb}, 32'd1);
      chk({tag, "_d"},    {28'd0, bus1.D},    32'd0);
      chk({tag, "_busy"}, {31'd0, bus1.BUSY}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus1.DONE}, 32'd0);
      chk({tag, "_err"},  {31'd0, bus1.ERR},  32'd0);
      chk({tag, "_wraps"},{24'd0, bus1.WRAPS},32'd0);
   endtask

   // Accept START on instance 1 and walk CLEAR and LOAD into the first RUN cycle.
   task automatic start1(input string tag, input logic [3:0] pre, input logic [3:0] exp_q);
      bus1.PRELOAD = pre;
      bus1.START   = 1'b1;
      tick();
      bus1.START   = 1'b0;
      chk({tag, "_clear_clrb"}, {31'd0, bus1.CLRb}, 32'd0);
      chk({tag, "_clear_busy"}, {31'd0, bus1.BUSY}, 32'd1);
      tick();
      chk({tag, "_load_ldb"}, {31'd0, bus1.LDb}, 32'd0);
      chk({tag, "_load_d"},   {28'd0, bus1.D},   {28'd0, pre});
      tick();
      chk({tag, "_run_q"},    {28'd0, bus1.Q},   {28'd0, exp_q});
      chk({tag, "_run_ldb"},  {31'd0, bus1.LDb}, 32'd1);
   endtask

   task automatic run1(input string tag, input logic [3:0] pre);
      int cycles;
      int steps;
      int first_step;
      cycles     = 0;
      steps      = 0;
      first_step = -1;
      start1(tag, pre, pre);
      while (!bus1.DONE && cycles < 200) begin
         if (bus1.ENP) begin
            if (first_step < 0) first_step = cycles;
            steps++;
         end
         cycles++;
         tick();
      end
      $display("%s: PRELOAD=%0d run_cycles=%0d steps=%0d WRAPS=%0d", tag, pre, cycles, steps, bus1.WRAPS);
      chk({tag, "_first_step"}, first_step, 32'd3);
      chk({tag, "_cycles"},     cycles,     32'd72);
      chk({tag, "_steps"},      steps,      32'd18);
      chk({tag, "_done"},       {31'd0, bus1.DONE},  32'd1);
      chk({tag, "_done_busy"},  {31'd0, bus1.BUSY},  32'd1);
      chk({tag, "_done_wraps"}, {24'd0, bus1.WRAPS}, 32'd2);
      chk({tag, "_done_q"},     {28'd0, bus1.Q},     32'd0);
      chk({tag, "_done_enp"},   {31'd0, bus1.ENP},   32'd0);
      tick();
      chk({tag, "_after_done"}, {31'd0, bus1.DONE},  32'd0);
      chk({tag, "_after_busy"}, {31'd0, bus1.BUSY},  32'd0);
      chk({tag, "_hold_wraps"}, {24'd0, bus1.WRAPS}, 32'd2);
      chk({tag, "_err"},        {31'd0, bus1.ERR},   32'd0);
   endtask

   initial begin
      int cycles;
      int steps;
      int dones;
      checks = 0;
      errors = 0;
      stuck  = 1'b0;
      cnt1   = 4'd0;
      cnt2   = 4'd0;
      rst    = 1'b1;
      bus1.START = 1'b0; bus1.STOP = 1'b0; bus1.PRELOAD = 4'd0;
      bus2.START = 1'b0; bus2.STOP = 1'b0; bus2.PRELOAD = 4'd0;

      // 1: reset, then idle with START low
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_idle1("t1_reset");
      chk("t1_dut2_busy", {31'd0, bus2.BUSY}, 32'd0);
      repeat (4) tick();
      chk("t1_idle_busy", {31'd0, bus1.BUSY}, 32'd0);
      $display("t1: reset and idle checked");

      // 2: full run from 14, two wraps
      run1("t2", 4'd14);

      // START together with STOP in IDLE is not accepted
      bus1.START = 1'b1; bus1.STOP = 1'b1;
      tick();
      bus1.START = 1'b0; bus1.STOP = 1'b0;
      chk("t2b_start_stop_busy", {31'd0, bus1.BUSY}, 32'd0);
      chk("t2b_start_stop_clrb", {31'd0, bus1.CLRb}, 32'd1);
      $display("t2b: START with STOP in IDLE ignored, BUSY=%0d", bus1.BUSY);

      // 3: PRELOAD=15 on the WRAP_TARGET=1 instance
      bus2.PRELOAD = 4'd15;
      bus2.START   = 1'b1;
      tick();
      bus2.START   = 1'b0;
      tick();
      tick();
      chk("t3_run_q", {28'd0, bus2.Q}, 32'd15);
      cycles = 0;
      steps  = 0;
      while (!bus2.DONE && cycles < 50) begin
         if (bus2.ENP) steps++;
         cycles++;
         tick();
      end
      chk("t3_cycles", cycles, 32'd4);
      chk("t3_steps",  steps,  32'd1);
      chk("t3_done",   {31'd0, bus2.DONE},  32'd1);
      chk("t3_wraps",  {24'd0, bus2.WRAPS}, 32'd1);
      chk("t3_q",      {28'd0, bus2.Q},     32'd0);
      dones = 0;
      repeat (6) begin
         tick();
         if (bus2.DONE) dones++;
      end
      chk("t3_single_done", dones, 32'd0);
      chk("t3_busy", {31'd0, bus2.BUSY}, 32'd0);
      $display("t3: PRELOAD=15 run_cycles=%0d WRAPS=%0d Q=%0d", cycles, bus2.WRAPS, bus2.Q);

      // 4: STOP coincides with the second wrap step
      start1("t4", 4'd14, 4'd14);
      repeat (71) tick();
      chk("t4_step_enp", {31'd0, bus1.ENP},   32'd1);
      chk("t4_step_q",   {28'd0, bus1.Q},     32'd15);
      chk("t4_wraps1",   {24'd0, bus1.WRAPS}, 32'd1);
      bus1.STOP = 1'b1;
      tick();
      bus1.STOP = 1'b0;
      chk("t4_done",  {31'd0, bus1.DONE},  32'd0);
      chk("t4_busy",  {31'd0, bus1.BUSY},  32'd0);
      chk("t4_wraps", {24'd0, bus1.WRAPS}, 32'd1);
      chk("t4_enp",   {31'd0, bus1.ENP},   32'd0);
      chk("t4_ent",   {31'd0, bus1.ENT},   32'd0);
      tick();
      chk("t4_no_late_done", {31'd0, bus1.DONE}, 32'd0);
      $display("t4: STOP on wrap step, WRAPS=%0d BUSY=%0d", bus1.WRAPS, bus1.BUSY);

      // 5: Q stuck at 3
      stuck = 1'b1;
      start1("t5", 4'd5, 4'd3);
      tick();
`ifdef SHADOW_CHECK_EN
      chk("t5_err",  {31'd0, bus1.ERR},  32'd1);
      chk("t5_busy", {31'd0, bus1.BUSY}, 32'd0);
      chk("t5_enp",  {31'd0, bus1.ENP},  32'd0);
      bus1.START = 1'b1;
      tick();
      tick();
      bus1.START = 1'b0;
      chk("t5_start_ignored_clrb", {31'd0, bus1.CLRb}, 32'd1);
      chk("t5_start_ignored_busy", {31'd0, bus1.BUSY}, 32'd0);
      chk("t5_err_sticky",         {31'd0, bus1.ERR},  32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_err", {31'd0, bus1.ERR}, 32'd0);
      $display("t5: stuck Q flagged and cleared by RST");
`else
      chk("t5_err_tied", {31'd0, bus1.ERR},  32'd0);
      chk("t5_busy",     {31'd0, bus1.BUSY}, 32'd1);
      bus1.STOP = 1'b1;
      tick();
      bus1.STOP = 1'b0;
      chk("t5_stop_busy", {31'd0, bus1.BUSY}, 32'd0);
      $display("t5: stuck Q, no shadow check, ERR=%0d", bus1.ERR);
`endif
      stuck = 1'b0;
      tick();

      // 6: RST mid-run, then a normal run
      start1("t6", 4'd5, 4'd5);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle1("t6_rst");
      $display("t6: RST mid-run returned to reset values");
      run1("t6_rerun", 4'd14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
